uart_pkt_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_byte_ser.sv | 117 +++++++++++
 rtl/uart_pkt_tx.sv | 132 +++++++++++++
 tb/tb_uart_pkt_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet transmitter.
//   - default baud divisor, byte width and sync byte
//   - byte-level FSM states (IDLE, SYNC, DATA, CSUM)
//   - bit-level FSM states (START, BITS, PARITY, STOP) plus an idle state
package uart_pkg;

    localparam int         CLOCKS_PER_PULSE_DEF = 10000;
    localparam int         BITS_PER_WORD_DEF    = 8;
    localparam logic [7:0] SYNC_BYTE_DEF        = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_CSUM
    } byte_state_t;

    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_BITS,
        BIT_PARITY,
        BIT_STOP
    } bit_state_t;

endpackage

// File: rtl/uart_byte_ser.sv
// UART byte serializer: start bit, data bits LSB first, optional even-parity
// bit, STOP_BITS stop bits. Every bit lasts CLOCKS_PER_PULSE cycles.
// Optional feature macro: UART_PKT_PARITY_EN (adds the parity bit).
//   clk, rstn : clock, asynchronous active-low reset
//   i_load    : load i_byte and start its frame (only while idle or on o_done)
//   i_byte    : byte to send
//   o_done    : high during the last cycle of the last stop bit
//   o_tx      : registered serial line, idle high
module uart_byte_ser
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
    parameter int BITS_PER_WORD    = BITS_PER_WORD_DEF,
    parameter int STOP_BITS        = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_load,
    input  logic [BITS_PER_WORD-1:0] i_byte,
    output logic                     o_done,
    output logic                     o_tx
);

    localparam int BAUD_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BIT_W  = $clog2(BITS_PER_WORD + STOP_BITS + 1);

    bit_state_t                r_state;
    logic [BAUD_W-1:0]         r_baud;
    logic [BIT_W-1:0]          r_bit;
    logic [BITS_PER_WORD-1:0]  r_shreg;
    logic                      r_tx;
`ifdef UART_PKT_PARITY_EN
    logic                      r_par;
`endif

    logic w_baud_last;
    logic w_stop_last;

    assign w_baud_last = (r_baud == BAUD_W'(CLOCKS_PER_PULSE - 1));
    assign w_stop_last = (r_bit == BIT_W'(STOP_BITS - 1));
    // Combinational so the sequencer can load the next byte on the same edge
    // and keep frames back-to-back.
    assign o_done      = (r_state == BIT_STOP) && w_baud_last && w_stop_last;
    assign o_tx        = r_tx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= BIT_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
`ifdef UART_PKT_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (i_load) begin
            // Start bit goes onto the line right after the load edge.
            r_state <= BIT_START;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shreg <= i_byte;
            r_tx    <= 1'b0;
`ifdef UART_PKT_PARITY_EN
            r_par   <= ^i_byte;
`endif
        end else if (r_state == BIT_IDLE) begin
            r_tx <= 1'b1;
        end else if (!w_baud_last) begin
            r_baud <= r_baud + 1'b1;
        end else begin
            r_baud <= '0;
            case (r_state)
                BIT_START: begin
                    r_state <= BIT_BITS;
                    r_bit   <= '0;
                    r_tx    <= r_shreg[0];
                    r_shreg <= r_shreg >> 1;
                end
                BIT_BITS: begin
                    if (r_bit == BIT_W'(BITS_PER_WORD - 1)) begin
                        r_bit <= '0;
`ifdef UART_PKT_PARITY_EN
                        r_state <= BIT_PARITY;
                        r_tx    <= r_par;
`else
                        r_state <= BIT_STOP;
                        r_tx    <= 1'b1;
`endif
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_tx    <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                    end
                end
                BIT_PARITY: begin
                    r_state <= BIT_STOP;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                end
                BIT_STOP: begin
                    if (w_stop_last) begin
                        r_state <= BIT_IDLE;
                        r_bit   <= '0;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                    r_tx <= 1'b1;
                end
                default: begin
                    r_state <= BIT_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_pkt_tx.sv
// Word-to-UART packet transmitter. Accepts one W_OUT-bit word per valid/ready
// handshake and sends SYNC_BYTE, the payload bytes LSB-byte first, then the
// byte-wide sum of the payload bytes.
// Optional feature macro: UART_PKT_PARITY_EN (even parity on every byte).
//   clk, rstn : clock, asynchronous active-low reset
//   s_valid   : upstream word valid
//   s_ready   : registered, high only in IDLE
//   s_data    : word to send, captured on acceptance
//   tx        : UART serial line, idle high
//   busy      : packet in progress (!s_ready)
module uart_pkt_tx
    import uart_pkg::*;
#(
    parameter int                     CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
    parameter int                     BITS_PER_WORD    = BITS_PER_WORD_DEF,
    parameter int                     W_OUT            = 32,
    parameter logic [BITS_PER_WORD-1:0] SYNC_BYTE      = BITS_PER_WORD'(SYNC_BYTE_DEF),
    parameter int                     STOP_BITS        = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_OUT-1:0] s_data,
    output logic             tx,
    output logic             busy
);

    localparam int NBYTES = W_OUT / BITS_PER_WORD;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    byte_state_t              r_state;
    logic                     r_s_ready;
    logic [W_OUT-1:0]         r_word;   // shifts down one byte per payload load
    logic [BITS_PER_WORD-1:0] r_csum;
    logic [IDX_W-1:0]         r_idx;    // payload byte currently on the line

    logic                     w_accept;
    logic                     w_done;
    logic                     w_load;
    logic                     w_last;
    logic [BITS_PER_WORD-1:0] w_byte;

    assign w_accept = s_valid && r_s_ready;
    assign w_last   = (r_idx == IDX_W'(NBYTES - 1));
    assign s_ready  = r_s_ready;
    assign busy     = !r_s_ready;

    // Next byte for the serializer, presented in the cycle its predecessor ends.
    always_comb begin
        w_load = 1'b0;
        w_byte = r_word[BITS_PER_WORD-1:0];
        case (r_state)
            ST_IDLE: begin
                w_load = w_accept;
                w_byte = SYNC_BYTE;
            end
            ST_SYNC: w_load = w_done;
            ST_DATA: begin
                w_load = w_done;
                // All payload bytes are already in r_csum once the last one is loaded.
                if (w_last) w_byte = r_csum;
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b1;
            r_word    <= '0;
            r_csum    <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_word    <= s_data;
                        r_csum    <= '0;
                        r_idx     <= '0;
                        r_s_ready <= 1'b0;
                        r_state   <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_done) begin
                        r_csum  <= r_csum + r_word[BITS_PER_WORD-1:0];
                        r_word  <= r_word >> BITS_PER_WORD;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_done) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= ST_CSUM;
                        end else begin
                            r_csum <= r_csum + r_word[BITS_PER_WORD-1:0];
                            r_word <= r_word >> BITS_PER_WORD;
                            r_idx  <= r_idx + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_done) begin
                        r_s_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_s_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    uart_byte_ser #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .BITS_PER_WORD    (BITS_PER_WORD),
        .STOP_BITS        (STOP_BITS)
    ) u_ser (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_load),
        .i_byte (w_byte),
        .o_done (w_done),
        .o_tx   (tx)
    );

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Bench for uart_pkt_tx with a fast baud divisor. The expected line waveform is
// built from the packet format (sync, payload bytes, byte sum, UART framing)
// and compared against tx every cycle of each packet.
module tb_uart_pkt_tx;

    localparam int CPP  = 4;
    localparam int BPW  = 8;
    localparam int WO   = 32;
    localparam int NB   = WO / BPW;
    localparam int STOP = 1;
`ifdef UART_PKT_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int FRAME = 1 + BPW + PAR + STOP;
    localparam int TOTAL = (NB + 2) * FRAME * CPP;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_valid;
    logic          s_ready;
    logic [WO-1:0] s_data;
    logic          tx;
    logic          busy;

    int tests = 0;
    int fails = 0;

    bit   exp_q[$];
    logic cap[$];

    uart_pkt_tx #(
        .CLOCKS_PER_PULSE (CPP),
        .BITS_PER_WORD    (BPW),
        .W_OUT            (WO),
        .SYNC_BYTE        (8'hA5),
        .STOP_BITS        (STOP)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int csum_of(input logic [31:0] d);
        int s = 0;
        for (int i = 0; i < NB; i++) s += (d >> (8 * i)) & 32'hFF;
        return s % 256;
    endfunction

    // Expected line level for every cycle-group (one entry per bit period).
    task automatic build_exp(input logic [31:0] d);
        int pb[NB+2];
        exp_q.delete();
        pb[0] = 8'hA5;
        for (int i = 0; i < NB; i++) pb[i+1] = (d >> (8 * i)) & 32'hFF;
        pb[NB+1] = csum_of(d);
        foreach (pb[j]) begin
            int ones = 0;
            exp_q.push_back(1'b0);
            for (int b = 0; b < BPW; b++) begin
                exp_q.push_back(pb[j][b]);
                ones += pb[j][b];
            end
            if (PAR == 1) exp_q.push_back(ones % 2 == 1);
            for (int s = 0; s < STOP; s++) exp_q.push_back(1'b1);
        end
    endtask

    // Called just after a negedge with the DUT idle. Returns at the negedge of
    // the first idle cycle after the packet (or after an abort by reset).
    task automatic run_packet(input logic [31:0] d, input int poke_at, input int abort_at,
                              input bit keep_valid, input logic [31:0] next_d);
        logic [7:0] got_cs;
        s_valid = 1'b1;
        s_data  = d;
        #1 chk("ready_before_accept", s_ready, 1);
        build_exp(d);
        cap.delete();
        @(posedge clk);
        @(negedge clk);
        if (keep_valid) s_data = next_d;
        else begin
            s_valid = 1'b0;
            s_data  = $urandom;
        end
        for (int k = 0; k < TOTAL; k++) begin
            if (k == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("abort_tx", tx, 1);
                chk("abort_ready", s_ready, 1);
                chk("abort_busy", busy, 0);
                @(negedge clk);
                chk("abort_hold_tx", tx, 1);
                rstn = 1'b1;
                return;
            end
            if (k == poke_at) begin
                s_valid = 1'b1;
                s_data  = $urandom;
            end
            if (k == poke_at + 1) begin
                chk("poke_ready_low", s_ready, 0);
                s_valid = 1'b0;
            end
            chk($sformatf("tx_cyc%0d", k), tx, exp_q[k / CPP]);
            chk("busy_ready_low", s_ready, 0);
            if (k % CPP == CPP / 2) cap.push_back(tx);
            if (k < TOTAL - 1) @(negedge clk);
        end
        @(negedge clk);
        chk("idle_ready", s_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_tx", tx, 1);
        for (int i = 0; i < 8; i++) got_cs[i] = cap[(NB + 1) * FRAME + 1 + i];
        chk("csum_byte", got_cs, csum_of(d));
    endtask

    initial begin
        rstn    = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        #3 rstn = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_tx", tx, 1);

        // Basic packet: A5 78 56 34 12 14, bit timing of SYNC included.
        run_packet(32'h12345678, -1, -1, 1'b0, 32'h0);

        // Back-to-back with valid held high: sums FC then 00.
        run_packet(32'hFFFFFFFF, -1, -1, 1'b1, 32'h00000000);
        run_packet(32'h00000000, -1, -1, 1'b0, 32'h0);

        // Valid pulsed while busy is ignored; later word accepted at once.
        run_packet($urandom, 57, -1, 1'b0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_wait_ready", s_ready, 1);
            chk("idle_wait_tx", tx, 1);
        end
        run_packet($urandom, 130, -1, 1'b0, 32'h0);

        // Reset during packet byte 2, then a complete fresh packet.
        run_packet(32'hCAFEBABE, -1, 2 * FRAME * CPP + 5, 1'b0, 32'h0);
        run_packet(32'h00000001, -1, -1, 1'b0, 32'h0);

        // Randomized words.
        for (int n = 0; n < 4; n++) run_packet($urandom, -1, -1, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
